// File: rtl/serial_add_seq_if.sv
// Handshake bundle for the bit-serial adder: operand request side and result side.
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
    logic             busy;

    modport master (
        output in_valid, a_in, b_in, cin_in, out_ready,
        input  in_ready, out_valid, sum_out, cout_out, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, cin_in, out_ready,
        output in_ready, out_valid, sum_out, cout_out, busy
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full_adder cell walked LSB-first over WIDTH cycles,
// operands in and result out through valid/ready handshakes.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_add_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10,
        TRAP = 2'b11
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             carry_reg, carry_next;
    logic             cout_reg, cout_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] result_shift;
    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a   (a_reg[0]),
        .b   (b_reg[0]),
        .cin (carry_reg),
        .s   (fa_s),
        .cout(fa_cout)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign result_shift[gi] = result_reg[gi+1];
        end
    endgenerate
    assign result_shift[WIDTH-1] = fa_s;

    assign last_bit = (count_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            result_reg <= result_next;
            sum_reg    <= sum_next;
            carry_reg  <= carry_next;
            cout_reg   <= cout_next;
            count_reg  <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        result_next = result_reg;
        sum_next    = sum_reg;
        carry_next  = carry_reg;
        cout_next   = cout_reg;
        count_next  = count_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next      = bus.a_in;
                    b_next      = bus.b_in;
                    carry_next  = bus.cin_in;
                    count_next  = '0;
                    result_next = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                a_next      = a_reg >> 1;
                b_next      = b_reg >> 1;
                result_next = result_shift;
                carry_next  = fa_cout;
                count_next  = count_reg + CW'(1);
                // Published copy keeps the visible result frozen while the next add runs.
                if (last_bit) begin
                    sum_next   = result_shift;
                    cout_next  = fa_cout;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.busy      = (state_reg == RUN);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.sum_out   = sum_reg;
    assign bus.cout_out  = cout_reg;
endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq at WIDTH=8 and WIDTH=1 against a cycle-level arithmetic model.
module tb_serial_add_seq;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add_seq_if #(.WIDTH(8)) bus8 ();
    serial_add_seq_if #(.WIDTH(1)) bus1 ();

    serial_add_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_add_seq #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int unsigned mw  [NW] = '{8, 1};
    logic [31:0] msk [NW] = '{32'hFF, 32'h1};

    logic        iv  [NW] = '{1'b0, 1'b0};
    logic        ordy[NW] = '{1'b0, 1'b0};
    logic        ci  [NW] = '{1'b0, 1'b0};
    logic [31:0] ai  [NW] = '{32'h0, 32'h0};
    logic [31:0] bi  [NW] = '{32'h0, 32'h0};
    logic        ir  [NW];
    logic        ov  [NW];
    logic        bz  [NW];
    logic        co  [NW];
    logic [31:0] so  [NW];

    assign bus8.in_valid  = iv[0];
    assign bus8.a_in      = ai[0][7:0];
    assign bus8.b_in      = bi[0][7:0];
    assign bus8.cin_in    = ci[0];
    assign bus8.out_ready = ordy[0];
    assign ir[0] = bus8.in_ready;
    assign ov[0] = bus8.out_valid;
    assign bz[0] = bus8.busy;
    assign co[0] = bus8.cout_out;
    assign so[0] = {24'h0, bus8.sum_out};

    assign bus1.in_valid  = iv[1];
    assign bus1.a_in      = ai[1][0:0];
    assign bus1.b_in      = bi[1][0:0];
    assign bus1.cin_in    = ci[1];
    assign bus1.out_ready = ordy[1];
    assign ir[1] = bus1.in_ready;
    assign ov[1] = bus1.out_valid;
    assign bz[1] = bus1.busy;
    assign co[1] = bus1.cout_out;
    assign so[1] = {31'h0, bus1.sum_out};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s w=%0d got=%h want=%h at cycle %0d", name, mw[k], act, exp, cyc);
        end
    endtask

    // Model: an accepted add is busy for exactly W cycles, then shows a+b+cin until consumed.
    int          m_left[NW] = '{0, 0};
    logic        m_done[NW] = '{1'b0, 1'b0};
    logic [32:0] m_pend[NW] = '{33'h0, 33'h0};
    logic [32:0] m_res [NW] = '{33'h0, 33'h0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) begin
                m_left[k] = 0;
                m_done[k] = 1'b0;
                m_res[k]  = '0;
            end
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (m_done[k]) begin
                    if (ordy[k]) m_done[k] = 1'b0;
                end else if (m_left[k] > 0) begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        m_done[k] = 1'b1;
                        m_res[k]  = m_pend[k];
                    end
                end else if (iv[k]) begin
                    m_left[k] = int'(mw[k]);
                    m_pend[k] = 33'(ai[k] & msk[k]) + 33'(bi[k] & msk[k]) + 33'(ci[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NW; k++) begin
            chk("in_ready", k, 32'(ir[k]), 32'(!m_done[k] && m_left[k] == 0));
            chk("busy", k, 32'(bz[k]), 32'(m_left[k] != 0));
            chk("out_valid", k, 32'(ov[k]), 32'(m_done[k]));
            chk("sum_out", k, so[k], m_res[k][31:0] & msk[k]);
            chk("cout_out", k, 32'(co[k]), 32'(m_res[k][mw[k]]));
        end
    end

    task automatic wait_sig(input int k, input bit vld, output int n);
        n = 0;
        while (!(vld ? ov[k] : ir[k])) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL timeout w=%0d waiting for %s got=0 want=1", mw[k], vld ? "out_valid" : "in_ready");
                return;
            end
        end
    endtask

    task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic c, input int hold,
                           input bit meddle, input bit lit, input logic [7:0] es, input logic ec);
        int n;
        int lat;
        wait_sig(0, 1'b0, n);
        ai[0] = 32'(a); bi[0] = 32'(b); ci[0] = c; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        lat = 0;
        if (meddle) begin
            ai[0] = $urandom; bi[0] = $urandom; ci[0] = 1'($urandom_range(0, 1));
            @(negedge clk); lat++;
            iv[0] = 1'b1;
            @(negedge clk); lat++;
            iv[0] = 1'b0;
        end
        wait_sig(0, 1'b1, n);
        lat += n;
        chk("latency", 0, 32'(lat), 32'd8);
        if (lit) begin
            chk("lit_sum", 0, so[0], 32'(es));
            chk("lit_cout", 0, 32'(co[0]), 32'(ec));
            chk("model_sum", 0, m_res[0][31:0] & msk[0], 32'(es));
        end
        $display("txn w=8 a=%h b=%h cin=%0d -> sum=%h cout=%0d latency=%0d hold=%0d", a, b, c, so[0][7:0], co[0], lat, hold);
        repeat (hold) @(negedge clk);
        ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;
        chk("ready_after_consume", 0, 32'(ir[0]), 32'd1);
    endtask

    logic [1:0] tbl[8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    initial begin
        int n;
        int last;
        int rs_cyc;
        @(negedge clk);
        chk("reset_in_ready", 0, 32'(ir[0]), 32'd1);
        chk("reset_out_valid", 0, 32'(ov[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_add8(8'h35, 8'h4A, 1'b0, 0, 1'b0, 1'b1, 8'h7F, 1'b0);
        do_add8(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b1);
        do_add8(8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h01, 1'b0);
        do_add8(8'hA5, 8'h5A, 1'b1, 5, 1'b0, 1'b1, 8'h00, 1'b1);
        do_add8(8'h12, 8'h34, 1'b0, 1, 1'b1, 1'b1, 8'h46, 1'b0);

        // Reset in the fourth RUN cycle discards the add.
        wait_sig(0, 1'b0, n);
        ai[0] = 32'hC3; bi[0] = 32'h7E; ci[0] = 1'b1; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 0, 32'(ir[0]), 32'd1);
        chk("rst_out_valid", 0, 32'(ov[0]), 32'd0);
        chk("rst_busy", 0, 32'(bz[0]), 32'd0);
        chk("rst_sum", 0, so[0], 32'd0);
        chk("rst_cout", 0, 32'(co[0]), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        rs_cyc = cyc;
        do_add8(8'h10, 8'h20, 1'b0, 0, 1'b0, 1'b1, 8'h30, 1'b0);
        $display("txn reset recovery started at cycle %0d", rs_cyc);

        for (int i = 0; i < 25; i++) begin
            do_add8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
        end

        // WIDTH=1, in_valid and out_ready held high: accepts every 3 cycles.
        ordy[1] = 1'b1;
        last = 0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            wait_sig(1, 1'b0, n);
            if (i > 0) chk("accept_spacing", 1, 32'(cyc - last), 32'd3);
            last = cyc;
            ai[1] = 32'(v[2]); bi[1] = 32'(v[1]); ci[1] = v[0]; iv[1] = 1'b1;
            @(negedge clk);
            wait_sig(1, 1'b1, n);
            chk("latency", 1, 32'(n), 32'd1);
            chk("cout_sum", 1, 32'({co[1], so[1][0]}), 32'(tbl[i]));
            $display("txn w=1 a=%0d b=%0d cin=%0d -> cout=%0d sum=%0d", v[2], v[1], v[0], co[1], so[1][0]);
            if (i == 7) iv[1] = 1'b0;
        end
        @(negedge clk);
        ordy[1] = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial adder controller that sequences a single 1-bit `full_adder` instance (ports `a`, `b`, `cin`, `s`, `cout`) over WIDTH clock cycles to add two WIDTH-bit operands plus a carry-in. It is the minimum-area addition engine for the sequential multiplier datapaths. It takes operands through a valid/ready handshake, runs LSB-first, and holds the result under a valid/ready handshake until the result is consumed.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands and carry-in presented
- in_ready  output  1  block can accept operands (high only in IDLE)
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- cin_in  input  1  carry-in to bit 0
- out_valid  output  1  sum_out/cout_out valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- sum_out  output  WIDTH  (a_in + b_in + cin_in) mod 2^WIDTH
- cout_out  output  1  carry out of bit WIDTH-1
- busy  output  1  high in RUN

## Operation
- Internal state: A/B shift registers (WIDTH), result shift register (WIDTH), carry flop, bit counter of width clog2(WIDTH+1), 2-bit FSM.
- The single `full_adder` instance is driven by A[0], B[0], and the carry flop. No other adder logic is permitted.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, load A<=a_in, B<=b_in, carry<=cin_in, count<=0, result<=0, then go to RUN.
  - RUN: each cycle A<=A>>1, B<=B>>1, result<={s, result[WIDTH-1:1]}, carry<=cout, count<=count+1. When count==WIDTH-1 this edge completes the last bit, and the FSM goes to DONE.
  - DONE: out_valid=1. sum_out=result, cout_out=carry, both held stable. On out_valid&out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Operands are sampled only on the accept edge, so later changes on a_in/b_in/cin_in have no effect.
- out_ready outside DONE has no effect.
- sum_out/cout_out hold their last value in IDLE and RUN; they are qualified only by out_valid.
- Encoding 2'b11 is unreachable. If entered, the FSM returns to IDLE on the next edge.
- Reset (asynchronous assert, any state, including mid-RUN): FSM=IDLE, all registers=0. Outputs: in_ready=1, out_valid=0, busy=0, sum_out=0, cout_out=0. The in-flight operation is discarded with no partial result.

## Timing
- Accept edge E (in_valid&in_ready sampled high).
- Bit i is computed in the cycle between edges E+i and E+i+1; its sum bit is registered at edge E+i+1.
- out_valid rises after edge E+WIDTH, giving a latency of WIDTH cycles from accept to result valid.
- busy is high from after E until after E+WIDTH.
- Result consumed at edge R (out_valid&out_ready): in_ready is high after R, and the next operand can be accepted at R+1 at the earliest.
- Peak throughput: one addition per WIDTH+2 cycles.
- With out_ready held low, DONE persists indefinitely with outputs stable.
- Back-to-back: in_valid held high continuously yields accepts at E, E+WIDTH+2, E+2(WIDTH+2), and so on, provided out_ready is high.
- WIDTH=1: RUN lasts exactly one cycle.
- Outputs are registered or decoded from FSM state only. There are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, a=8'h35, b=8'h4A, cin=0, out_ready=1 → out_valid exactly 8 cycles after the accept edge, sum_out=8'h7F, cout_out=0, busy high for 8 cycles.
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 → sum_out=8'h00, cout_out=1. Then a=8'h00, b=8'h00, cin=1 → sum_out=8'h01, cout_out=0.
- Backpressure: a=8'hA5, b=8'h5A, cin=1, out_ready low for 5 cycles after out_valid → sum_out=8'h00, cout_out=1 held stable, in_ready=0 throughout. Raising out_ready gives in_ready=1 on the next cycle.
- In RUN, change a_in/b_in and pulse in_valid → ignored. The result still matches the operands latched at the accept edge.
- Assert rst_n=0 at cycle 4 of RUN → immediately in_ready=1, out_valid=0, busy=0, sum_out=0. A following 8'h10+8'h20 gives 8'h30 with normal latency.
- WIDTH=1, all 8 (a,b,cin) combinations in order 000..111 → (cout,sum)=00,01,01,10,01,10,10,11. Each result arrives 1 cycle after accept, and the spacing between accepts is 3 cycles.
